multi_button_arbiter: RTL

//  N-player push-button arbiter for the tug-of-war game; successor to the 2-player latch.

---
 rtl/multi_button_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/multi_button_arbiter.sv
// N-player push-button arbiter: per-button synchroniser and debouncer feeding an
// IDLE/ARMED/LOCKED round FSM that captures the first press(es) and holds the result.
module multi_button_arbiter #(
    parameter int N_PLAYERS       = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FOUL_EN         = 1,
    localparam int IW             = $clog2(N_PLAYERS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_PLAYERS-1:0] pb,
    input  logic                 arm,
    input  logic                 clear,
    output logic                 push,
    output logic                 push_pulse,
    output logic [N_PLAYERS-1:0] winner,
    output logic [IW-1:0]        winner_idx,
    output logic                 tie,
    output logic                 foul
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    logic [N_PLAYERS-1:0] sync_q [SYNC_STAGES];
    logic [N_PLAYERS-1:0] s;
    logic [N_PLAYERS-1:0] db;
    logic [N_PLAYERS-1:0] db_d;
    logic [CW-1:0]        cnt [N_PLAYERS];
    logic [N_PLAYERS-1:0] press;
    logic [IW-1:0]        idx_nx;
    logic                 multi;
    logic                 capture;
    logic                 capture_foul;
    state_t               state, state_nx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= pb;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // A mismatch must persist DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db   <= '0;
            db_d <= '0;
            for (int unsigned i = 0; i < N_PLAYERS; i++) cnt[i] <= '0;
        end else begin
            db_d <= db;
            for (int unsigned i = 0; i < N_PLAYERS; i++) begin
                if (s[i] != db[i]) begin
                    if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                        db[i]  <= s[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    assign press = db & ~db_d;
    assign multi = |(press & (press - {{(N_PLAYERS-1){1'b0}}, 1'b1}));

    always_comb begin
        idx_nx = '0;
        for (int unsigned i = N_PLAYERS; i > 0; i--) begin
            if (press[i-1]) idx_nx = IW'(i - 1);
        end
    end

    always_comb begin
        state_nx     = state;
        capture      = 1'b0;
        capture_foul = 1'b0;
        case (state)
            S_IDLE: begin
                if (clear) begin
                    state_nx = S_IDLE;
                end else if (arm) begin
                    state_nx = S_ARMED;
                end else if ((|press) && (FOUL_EN != 0)) begin
                    state_nx     = S_LOCKED;
                    capture      = 1'b1;
                    capture_foul = 1'b1;
                end
            end
            S_ARMED: begin
                if (clear) begin
                    state_nx = S_IDLE;
                end else if (arm) begin
                    state_nx = S_ARMED;
                end else if (|press) begin
                    state_nx = S_LOCKED;
                    capture  = 1'b1;
                end
            end
            S_LOCKED: begin
                if (clear) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            push       <= 1'b0;
            push_pulse <= 1'b0;
            winner     <= '0;
            winner_idx <= '0;
            tie        <= 1'b0;
            foul       <= 1'b0;
        end else begin
            state      <= state_nx;
            push       <= (state_nx == S_LOCKED);
            push_pulse <= capture;
            if (capture) begin
                winner     <= press;
                winner_idx <= idx_nx;
                tie        <= multi;
                foul       <= capture_foul;
            end else if (state_nx != S_LOCKED) begin
                winner     <= '0;
                winner_idx <= '0;
                tie        <= 1'b0;
                foul       <= 1'b0;
            end
        end
    end

endmodule
